// File: rtl/pc_sequencer_if.sv
// Descriptor handshake and PC-update bus between decode/execute and the PC sequencer.
interface pc_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        is_branch;
  logic        is_jump;
  logic        is_call;
  logic        is_ret;
  logic        cond_valid;
  logic        cond_zero;
  logic        pc_write;
  logic [1:0]  sig_pc_src;
  logic [31:0] return_address;

  modport master (
    output instr_valid, pc, is_branch, is_jump, is_call, is_ret, cond_valid, cond_zero,
    input  instr_ready, pc_write, sig_pc_src, return_address
  );

  modport slave (
    input  instr_valid, pc, is_branch, is_jump, is_call, is_ret, cond_valid, cond_zero,
    output instr_ready, pc_write, sig_pc_src, return_address
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC update sequencer with a circular return-address stack.
// Define PC_SEQ_PERF_CNT_EN to build the stall/taken performance counters.
module pc_sequencer #(
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  pc_sequencer_if.slave     bus,
  input  logic              err_clear,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_taken_cnt
);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_BRWAIT, S_UPDATE} state_t;
  state_t state;

  logic              instr_ready_q;
  logic              pc_write_q;
  logic [1:0]        src_q;
  logic [31:0]       ret_addr_q;
  logic [31:0]       ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx, nxt_idx, ptr_nxt, waddr;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept, ras_empty, ras_full, dec_branch;
  logic              do_pop, do_push, pop_ok, ovf_evt, unf_evt;
  logic [1:0]        dec_src;
  logic [31:0]       pc_plus4;

  always_comb begin
    accept     = (state == S_RUN) && bus.instr_valid;
    pc_plus4   = bus.pc + 32'd4;
    ras_empty  = (ras_count == '0);
    ras_full   = (ras_count == CNT_W'(RAS_DEPTH));
    top_idx    = (ptr == '0) ? PTR_W'(RAS_DEPTH-1) : ptr - PTR_W'(1);
    nxt_idx    = (ptr == PTR_W'(RAS_DEPTH-1)) ? '0 : ptr + PTR_W'(1);
    dec_branch = !bus.is_ret && bus.is_branch;
    do_pop     = accept && bus.is_ret;
    do_push    = accept && bus.is_call && !dec_branch;
    pop_ok     = do_pop && !ras_empty;
    unf_evt    = do_pop && ras_empty;
    ovf_evt    = do_push && !pop_ok && ras_full;

    if (bus.is_ret)                      dec_src = ras_empty ? 2'b00 : 2'b01;
    else if (bus.is_call || bus.is_jump) dec_src = 2'b11;
    else                                 dec_src = 2'b00;

    // Pop+push reuses the popped slot, so pointer and count stay put.
    ptr_nxt = ptr;
    cnt_nxt = ras_count;
    waddr   = ptr;
    if (pop_ok && do_push) begin
      waddr = top_idx;
    end else if (pop_ok) begin
      ptr_nxt = top_idx;
      cnt_nxt = ras_count - CNT_W'(1);
    end else if (do_push) begin
      ptr_nxt = nxt_idx;
      cnt_nxt = ras_full ? ras_count : ras_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) ras_mem[waddr] <= pc_plus4;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_RUN;
      instr_ready_q <= 1'b1;
      pc_write_q    <= 1'b0;
      src_q         <= 2'b00;
      ret_addr_q    <= '0;
      ras_count     <= '0;
      ptr           <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_write_q    <= 1'b0;
      ptr           <= ptr_nxt;
      ras_count     <= cnt_nxt;
      ras_overflow  <= (ras_overflow & ~err_clear) | ovf_evt;
      ras_underflow <= (ras_underflow & ~err_clear) | unf_evt;
      case (state)
        S_RUN: begin
          if (bus.instr_valid) begin
            instr_ready_q <= 1'b0;
            if (dec_branch) begin
              state <= S_BRWAIT;
            end else begin
              state      <= S_UPDATE;
              pc_write_q <= 1'b1;
              src_q      <= dec_src;
              if (pop_ok) ret_addr_q <= ras_mem[top_idx];
            end
          end
        end
        S_BRWAIT: begin
          if (bus.cond_valid) begin
            state      <= S_UPDATE;
            pc_write_q <= 1'b1;
            src_q      <= bus.cond_zero ? 2'b10 : 2'b00;
          end
        end
        S_UPDATE: begin
          state         <= S_RUN;
          instr_ready_q <= 1'b1;
        end
        default: begin
          state         <= S_RUN;
          instr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instr_ready    = instr_ready_q;
  assign bus.pc_write       = pc_write_q;
  assign bus.sig_pc_src     = src_q;
  assign bus.return_address = ret_addr_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] stall_q, taken_q;
  logic        stall_inc, taken_inc;

  // The accepting cycle of a branch counts as the first stall cycle.
  assign stall_inc = (state == S_BRWAIT) || (accept && dec_branch);
  assign taken_inc = (accept && !dec_branch && (dec_src != 2'b00)) ||
                     ((state == S_BRWAIT) && bus.cond_valid && bus.cond_zero);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      taken_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 16'd1;
      if (taken_inc && (taken_q != '1)) taken_q <= taken_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_taken_cnt = taken_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_taken_cnt = '0;
`endif
endmodule
